// File: rtl/exec_ctrl_pkg.sv
// exec_ctrl_pkg: state encoding and parameter defaults shared by the run/step/halt controller.
package exec_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STEP = 2'b10, HALTED = 2'b11} state_t;
  localparam int SAMPLE_PERIOD_DEF = 2_000_000;
  localparam int STEP_CYCLES_DEF = 1;
endpackage

// File: rtl/exec_ctrl_btn_sampler.sv
// btn_sampler: samples an active-low button on the shared tick and emits a one-cycle press pulse.
module btn_sampler (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn,
  output logic press
);
  logic s0_q, s0_d, s1_q, s1_d;
  always_comb begin
    s0_d = tick ? !btn : s0_q;
    s1_d = tick ? s0_q : s1_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q <= 1'b0;
      s1_q <= 1'b0;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
    end
  end
  // Rising edge of the sampled level, seen only on a tick so it lasts one cycle.
  assign press = tick && s0_q && !s1_q;
endmodule

// File: rtl/exec_ctrl.sv
// exec_ctrl: run/step/halt controller gating the pipeline clock enable.
// Single-step support is built only when EXEC_CTRL_STEP_EN is defined.
module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int SAMPLE_PERIOD = SAMPLE_PERIOD_DEF,
  parameter int STEP_CYCLES   = STEP_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_run,
  input  logic       btn_step,
  input  logic       cpu_halt,
  output logic       cpu_en,
  output logic [1:0] state,
  output logic       step_done
);
  localparam int CW = $clog2(SAMPLE_PERIOD + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic tick, run_press, step_press, step_last;
  state_t state_q, state_d;
  logic cpu_en_q, cpu_en_d, step_done_q, step_done_d;
  assign cnt_d = (cnt_q == CW'(SAMPLE_PERIOD)) ? '0 : cnt_q + 1'b1;
  assign tick = cnt_q == CW'(SAMPLE_PERIOD / 2);
  btn_sampler u_run (.clk(clk), .rst_n(rst_n), .tick(tick), .btn(btn_run), .press(run_press));
`ifdef EXEC_CTRL_STEP_EN
  localparam int SW = $clog2(STEP_CYCLES + 1);
  logic [SW-1:0] scnt_q, scnt_d;
  btn_sampler u_step (.clk(clk), .rst_n(rst_n), .tick(tick), .btn(btn_step), .press(step_press));
  always_comb begin
    scnt_d = (state_q == IDLE && !run_press && step_press) ? SW'(STEP_CYCLES) :
             (state_q == STEP) ? scnt_q - 1'b1 : scnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scnt_q <= '0;
    else scnt_q <= scnt_d;
  end
  assign step_last = scnt_q == SW'(1);
`else
  logic unused_step;
  assign unused_step = btn_step | (STEP_CYCLES < 1);
  assign step_press = 1'b0;
  assign step_last = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    step_done_d = 1'b0;
    case (state_q)
      IDLE:    state_d = run_press ? RUN : step_press ? STEP : IDLE;
      RUN:     state_d = cpu_halt ? HALTED : run_press ? IDLE : RUN;
      STEP: begin
        state_d = cpu_halt ? HALTED : step_last ? IDLE : STEP;
        step_done_d = !cpu_halt && step_last;
      end
      HALTED:  state_d = run_press ? IDLE : HALTED;
      default: state_d = IDLE;
    endcase
    cpu_en_d = state_d == RUN || state_d == STEP;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      state_q     <= IDLE;
      cpu_en_q    <= 1'b0;
      step_done_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      cpu_en_q    <= cpu_en_d;
      step_done_q <= step_done_d;
    end
  end
  assign cpu_en = cpu_en_q;
  assign state = state_q;
  assign step_done = step_done_q;
endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl: randomized and directed checks of exec_ctrl against a behavioural model.
module tb_exec_ctrl;
  localparam int SP = 8;
  localparam int STEPS = 3;
`ifdef EXEC_CTRL_STEP_EN
  localparam bit STEP_ON = 1'b1;
`else
  localparam bit STEP_ON = 1'b0;
`endif
  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;
  logic clk = 1'b0, rst_n, btn_run, btn_step, cpu_halt;
  logic cpu_en, step_done;
  logic [1:0] state;
  int n_tests = 0, n_fail = 0;
  int m_cnt, m_mode, m_left;
  bit r_new, r_old, s_new, s_old, m_done;
  logic [1:0] exp_state;
  logic exp_en, exp_done;

  exec_ctrl #(.SAMPLE_PERIOD(SP), .STEP_CYCLES(STEPS)) dut (
    .clk(clk), .rst_n(rst_n), .btn_run(btn_run), .btn_step(btn_step),
    .cpu_halt(cpu_halt), .cpu_en(cpu_en), .state(state), .step_done(step_done));

  always #5 clk = ~clk;

  function automatic void m_reset();
    m_cnt = 0; m_mode = M_IDLE; m_left = 0; m_done = 0;
    r_new = 0; r_old = 0; s_new = 0; s_old = 0;
    exp_state = 2'b00; exp_en = 1'b0; exp_done = 1'b0;
  endfunction

  // Model: the counter is just cycles since reset mod (SP+1); presses come from the last two samples.
  task automatic step_clk();
    bit tk, rp, sp;
    tk = (m_cnt == SP / 2);
    rp = tk && r_new && !r_old;
    sp = STEP_ON && tk && s_new && !s_old;
    if (tk) begin
      r_old = r_new; r_new = !btn_run;
      s_old = s_new; s_new = !btn_step;
    end
    m_cnt = (m_cnt == SP) ? 0 : m_cnt + 1;
    m_done = 0;
    if (m_mode == M_STEP) m_left--;
    if ((m_mode == M_RUN || m_mode == M_STEP) && cpu_halt) m_mode = M_HALT;
    else if (m_mode == M_STEP && m_left == 0) begin m_mode = M_IDLE; m_done = 1; end
    else if (rp) m_mode = (m_mode == M_IDLE) ? M_RUN : (m_mode == M_STEP) ? M_STEP : M_IDLE;
    else if (sp && m_mode == M_IDLE) begin m_mode = M_STEP; m_left = STEPS; end
    exp_state = 2'(m_mode);
    exp_en = (m_mode == M_RUN || m_mode == M_STEP);
    exp_done = m_done;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_run = 1'b1; btn_step = 1'b1; cpu_halt = 1'b0;
    m_reset();
    #2;
    n_tests++;
    if (state !== 2'b00 || cpu_en !== 1'b0 || step_done !== 1'b0) begin
      n_fail++; $display("FAIL reset: state=%0d en=%b done=%b, want 0 0 0", state, cpu_en, step_done);
    end
    rst_n = 1'b1;
    repeat (12) begin
      step_clk(); n_tests++;
      if (state !== exp_state || cpu_en !== exp_en || step_done !== exp_done) begin
        n_fail++; $display("FAIL reset_idle: got %0d/%b/%b want %0d/%b/%b", state, cpu_en, step_done, exp_state, exp_en, exp_done);
      end
    end
  endtask

  task automatic test_run_stop();
    for (int p = 0; p < 4; p++) begin
      btn_run = p[0];
      repeat (20) begin
        step_clk(); n_tests++;
        if (state !== exp_state || cpu_en !== exp_en || step_done !== exp_done) begin
          n_fail++; $display("FAIL run_stop: got %0d/%b/%b want %0d/%b/%b", state, cpu_en, step_done, exp_state, exp_en, exp_done);
        end
      end
      if (p == 0) begin
        n_tests++;
        if (state !== 2'b01 || cpu_en !== 1'b1) begin
          n_fail++; $display("FAIL run_start: state=%0d en=%b, want 1 1", state, cpu_en);
        end
      end
    end
    n_tests++;
    if (state !== 2'b00 || cpu_en !== 1'b0) begin
      n_fail++; $display("FAIL run_stop_end: state=%0d en=%b, want 0 0", state, cpu_en);
    end
  endtask

  task automatic test_halt();
    btn_run = 1'b0; repeat (20) step_clk();
    btn_run = 1'b1; repeat (20) step_clk();
    cpu_halt = 1'b1; step_clk(); cpu_halt = 1'b0;
    n_tests++;
    if (state !== 2'b11 || cpu_en !== 1'b0) begin
      n_fail++; $display("FAIL halt_run: state=%0d en=%b, want 3 0", state, cpu_en);
    end
    btn_step = 1'b0; repeat (20) step_clk();
    btn_step = 1'b1; repeat (20) step_clk();
    n_tests++;
    if (state !== 2'b11 || cpu_en !== 1'b0 || step_done !== 1'b0) begin
      n_fail++; $display("FAIL halt_step_ignored: state=%0d en=%b done=%b, want 3 0 0", state, cpu_en, step_done);
    end
    btn_run = 1'b0; repeat (20) step_clk();
    btn_run = 1'b1; repeat (20) step_clk();
    n_tests++;
    if (state !== 2'b00 || cpu_en !== 1'b0) begin
      n_fail++; $display("FAIL halt_ack: state=%0d en=%b, want 0 0", state, cpu_en);
    end
  endtask

  task automatic test_simultaneous_press();
    btn_run = 1'b0; btn_step = 1'b0; repeat (20) step_clk();
    btn_run = 1'b1; btn_step = 1'b1; repeat (20) step_clk();
    n_tests++;
    if (state !== 2'b01 || cpu_en !== 1'b1) begin
      n_fail++; $display("FAIL both_press: state=%0d en=%b, want 1 1", state, cpu_en);
    end
    btn_run = 1'b0; repeat (20) step_clk();
    btn_run = 1'b1; repeat (20) step_clk();
  endtask

`ifdef EXEC_CTRL_STEP_EN
  task automatic test_step_burst();
    int en_cnt, done_cnt;
    en_cnt = 0; done_cnt = 0;
    btn_step = 1'b0;
    repeat (45) begin
      step_clk(); n_tests++;
      en_cnt += int'(cpu_en === 1'b1);
      done_cnt += int'(step_done === 1'b1);
      if (state !== exp_state || cpu_en !== exp_en || step_done !== exp_done) begin
        n_fail++; $display("FAIL step_burst: got %0d/%b/%b want %0d/%b/%b", state, cpu_en, step_done, exp_state, exp_en, exp_done);
      end
    end
    btn_step = 1'b1; repeat (20) step_clk();
    n_tests++;
    if (en_cnt != STEPS || done_cnt != 1 || state !== 2'b00) begin
      n_fail++; $display("FAIL step_count: en_cycles=%0d dones=%0d state=%0d, want %0d 1 0", en_cnt, done_cnt, state, STEPS);
    end
  endtask

  task automatic test_step_halt_last();
    int k;
    k = 0;
    btn_step = 1'b0;
    while (k < 40 && cpu_en !== 1'b1) begin step_clk(); k++; end
    btn_step = 1'b1;
    n_tests++;
    if (cpu_en !== 1'b1) begin
      n_fail++; $display("FAIL step_start: en=%b, want 1", cpu_en);
    end
    repeat (STEPS - 1) step_clk();
    cpu_halt = 1'b1; step_clk(); cpu_halt = 1'b0;
    n_tests++;
    if (state !== 2'b11 || cpu_en !== 1'b0 || step_done !== 1'b0) begin
      n_fail++; $display("FAIL step_halt_last: state=%0d en=%b done=%b, want 3 0 0", state, cpu_en, step_done);
    end
    btn_run = 1'b0; repeat (20) step_clk();
    btn_run = 1'b1; repeat (20) step_clk();
  endtask

  task automatic test_reset_mid_step();
    int k;
    k = 0;
    btn_step = 1'b0;
    while (k < 40 && cpu_en !== 1'b1) begin step_clk(); k++; end
    btn_step = 1'b1;
    repeat (STEPS - 1) step_clk();
    rst_n = 1'b0;
    #2;
    n_tests++;
    if (state !== 2'b00 || cpu_en !== 1'b0 || step_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_step: state=%0d en=%b done=%b, want 0 0 0", state, cpu_en, step_done);
    end
    m_reset();
    rst_n = 1'b1;
    for (int p = 0; p < 3; p++) begin
      btn_run = (p != 1);
      repeat (20) begin
        step_clk(); n_tests++;
        if (state !== exp_state || cpu_en !== exp_en || step_done !== 1'b0) begin
          n_fail++; $display("FAIL after_reset: got %0d/%b/%b want %0d/%b/0", state, cpu_en, step_done, exp_state, exp_en);
        end
      end
    end
    btn_run = 1'b0; repeat (20) step_clk();
    btn_run = 1'b1; repeat (20) step_clk();
  endtask
`else
  task automatic test_step_ignored();
    int bad;
    bad = 0;
    for (int p = 0; p < 4; p++) begin
      btn_step = p[0];
      repeat (20) begin
        step_clk();
        bad += int'(state === 2'b10 || step_done !== 1'b0 || cpu_en !== 1'b0);
      end
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL step_ignored: bad_cycles=%0d, want 0", bad);
    end
  endtask
`endif

  task automatic test_random();
    repeat (1500) begin
      if ($urandom_range(0, 11) == 0) btn_run = !btn_run;
      if ($urandom_range(0, 11) == 0) btn_step = !btn_step;
      cpu_halt = ($urandom_range(0, 15) == 0);
      step_clk(); n_tests++;
      if (state !== exp_state || cpu_en !== exp_en || step_done !== exp_done) begin
        n_fail++; $display("FAIL random: got %0d/%b/%b want %0d/%b/%b", state, cpu_en, step_done, exp_state, exp_en, exp_done);
      end
    end
    cpu_halt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run_stop();
    test_halt();
    test_simultaneous_press();
`ifdef EXEC_CTRL_STEP_EN
    test_step_burst();
    test_step_halt_last();
    test_reset_mid_step();
`else
    test_step_ignored();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/exec_ctrl.md
# exec_ctrl

Run/step/halt execution controller for the pipelined SIMPLE processor on the FPGA board. It samples two raw push buttons on a shared slow tick and turns each press into a single-cycle event. A four-state machine sequences the pipeline's clock enable from those events: free-run, single-step bursts, or stop when the processor retires a halt instruction.

## Interface
Parameters:
- `SAMPLE_PERIOD`, default 2_000_000: tick counter wraps from this value to 0; buttons are sampled when the count equals `SAMPLE_PERIOD/2`.
- `STEP_CYCLES`, default 1: number of cycles `cpu_en` is held high per step press; legal range ≥ 1.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `btn_run`, input, 1: raw run button, low when pressed.
- `btn_step`, input, 1: raw step button, low when pressed.
- `cpu_halt`, input, 1: one-cycle pulse from the pipeline when a halt instruction retires.
- `cpu_en`, output, 1: clock enable for all pipeline registers.
- `state`, output, 2: current FSM state, for LEDs.
- `step_done`, output, 1: one-cycle pulse when a step burst completes normally.

## Operation
- **Tick counter.** Free-running counter of width `$clog2(SAMPLE_PERIOD+1)`.
  - Sequence: 0 → … → `SAMPLE_PERIOD` → 0.
  - `tick` is high for the single cycle where count == `SAMPLE_PERIOD/2`.
- **Button sampling.** Each button has two sample flops, `s1 <= s0; s0 <= !btn`, updated only on `tick`.
  - A press event is `s1==0 && s0==1`, evaluated on a tick cycle.
  - Each press yields exactly one `run_press` or `step_press` pulse, one cycle long.
  - Holding a button yields no further events.
- **FSM states** (encoding in parentheses):
  - IDLE (2'b00): `cpu_en=0`.
    - `run_press` → RUN.
    - `step_press` → STEP; step counter loads `STEP_CYCLES`.
    - If both occur in the same cycle, `run_press` wins.
  - RUN (2'b01): `cpu_en=1`.
    - `cpu_halt` → HALTED.
    - Otherwise `run_press` → IDLE.
    - `step_press` is ignored.
  - STEP (2'b10): `cpu_en=1`.
    - Counter decrements each cycle.
    - On the cycle the counter reads 1: next state is IDLE and `step_done` pulses.
    - `cpu_halt` → HALTED with no `step_done`; halt wins over completion in the same cycle.
    - Presses are ignored.
  - HALTED (2'b11): `cpu_en=0`.
    - `run_press` → IDLE (acknowledge only; it does not restart the processor).
    - `step_press` is ignored.
- **`cpu_halt` outside RUN/STEP.** Ignored.

## Timing
- **Reset values.** Reset clears:
  - `cpu_en=0`, `state=IDLE`, `step_done=0`;
  - the tick counter to 0;
  - all sample flops to 0;
  - the step counter to 0.
- **Registered outputs.** `cpu_en`, `state` and `step_done` are flops, updated in the same edge as the FSM.
- **Press latency.** A press event on tick cycle T changes `state` and `cpu_en` at edge T+1.
- **Step burst.** `cpu_en` is high for exactly `STEP_CYCLES` consecutive cycles. `step_done` is high in the first cycle after the burst, the same cycle `cpu_en` returns to 0.
- **Halt latency.** A `cpu_halt` pulse at cycle T gives `cpu_en=0` from T+1. The pipeline has already committed the halt instruction in cycle T.
- **Reset mid-operation.** `rst_n` low forces IDLE immediately and asynchronously, including mid-step. A step burst interrupted this way never produces `step_done`.
- **Counter wrap.** The tick counter wraps with no skipped value; the tick spacing is exactly `SAMPLE_PERIOD+1` cycles.

## Configuration
- **Macro:** `EXEC_CTRL_STEP_EN`.
- **Defined:** single-step is supported as described above.
- **Undefined:**
  - the `btn_step` sampler and the step counter are not built;
  - STEP is unreachable;
  - `step_done` is tied to 0;
  - `btn_step` is ignored.
  - The port list is unchanged.

## Structure
- **Package `exec_ctrl_pkg`** holds:
  - `state_t` enum: IDLE, RUN, STEP, HALTED, with the 2-bit encodings above;
  - defaults `SAMPLE_PERIOD_DEF=2_000_000` and `STEP_CYCLES_DEF=1`.
- **Sub-module `btn_sampler`** (instantiated once per button).
  - Inputs: `clk`, `rst_n`, `tick`, raw `btn`.
  - Output: one-cycle `press`.
  - The tick counter lives in `exec_ctrl` and is shared by both samplers.

## Test plan
All scenarios use `SAMPLE_PERIOD=8` (tick at count 4, tick spacing 9 cycles) unless stated.
- **Run/stop.** Hold `btn_run` low across 2 ticks → `cpu_en` rises 1 cycle after the second tick and stays high. Release, then press again → `cpu_en` falls and `state`=00.
- **Step burst.** With `STEP_CYCLES=3`, press step in IDLE → `cpu_en` high for exactly 3 cycles, then `step_done` pulses once and `state`=00. Holding the button produces no second burst.
- **Halt in RUN.** In RUN, pulse `cpu_halt` → next cycle `cpu_en=0` and `state`=11. Then:
  - a step press changes nothing;
  - a run press gives `state`=00 with `cpu_en` still 0.
- **Simultaneous events.**
  - `cpu_halt` on the last STEP cycle → `state`=11 and no `step_done`.
  - Run and step presses on the same tick in IDLE → RUN.
- **Reset mid-step.** With `STEP_CYCLES=5`, drop `rst_n` after 2 enabled cycles → all outputs 0 and `state`=00 immediately. After release the tick counter restarts from 0 and no `step_done` ever appears.
- **Macro undefined.** Step presses are ignored: `state` never reads 10 and `step_done` stays 0. Run/halt behaviour is identical to the run/stop and halt scenarios.
